heartbeat_failover: RTL
=======================

Name: heartbeat_failover

Overview:
N-channel successor to the two-channel PWM heartbeat detection used by the core switch. Each channel monitors one CPU heartbeat square wave and declares the CPU alive or dead using a timeout window and a recovery edge count. A failover arbiter chooses the active CPU, which drives the UART/switch routing in core. Automatic failover and forced switching from the command module are both supported, with a hold-off after each switch.

Parameters:
N_CH, 4, number of CPU heartbeat channels (2..8)
SEL_W, 2, width of channel index; must equal clog2(N_CH)
CNT_W, 24, width of the per-channel timeout counter
TIMEOUT, 24'd2_000_000, clk cycles with no rising edge before a channel is declared dead
MIN_EDGES, 3, consecutive in-window rising edges needed to declare a channel alive (1..15)
HOLDOFF, 24'd500_000, clk cycles after any switch during which forced switches are ignored

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pwm  in  N_CH  raw asynchronous heartbeat inputs, bit i belongs to CPU i
force_swi  in  1  single-cycle request to switch to force_sel
force_sel  in  SEL_W  requested target channel
io  out  N_CH  per-channel alive flags
active_sel  out  SEL_W  currently selected CPU
switch  out  1  single-cycle pulse on every change of active_sel
all_dead  out  1  high while no channel is alive
force_rej  out  1  single-cycle pulse when a force request is rejected

Behaviour:
- Reset values: io=0, active_sel=0, switch=0, all_dead=1, force_rej=0. All counters and FSMs are cleared. Reset is honoured mid-operation with no residual state.
- Per channel: 2-flop synchroniser on pwm[i], then rising-edge detect (edge = sync_q1 & ~sync_q2). Edge-to-internal latency is 3 clk.
- Per-channel counter cnt:
  - On an edge, cnt clears to 0.
  - Otherwise cnt increments, saturating at TIMEOUT. No wrap.
- Per-channel FSM:
  - DEAD: an edge moves to RECOVER with ecnt=1. If MIN_EDGES==1, it moves straight to ALIVE.
  - RECOVER: an edge increments ecnt; when ecnt reaches MIN_EDGES, move to ALIVE. If cnt reaches TIMEOUT, return to DEAD with ecnt=0.
  - ALIVE: if cnt reaches TIMEOUT, move to DEAD.
  - io[i]=1 only in ALIVE, registered, asserted the cycle after the transition.
  - A steady high or steady low input is dead: only edges count.
- Arbiter FSM:
  - NONE: all_dead=1. When any io bit is set, select the lowest alive index, pulse switch (only if the index differs), load holdoff, go to RUN.
  - RUN: if io[active_sel] falls, select the next alive index in round-robin order after active_sel (wrapping at N_CH-1 to 0), pulse switch, reload holdoff.
    - If no channel is alive, go to NONE; active_sel holds its last value and switch does not pulse.
  - force_swi in RUN is accepted only if all of the following hold: holdoff==0, force_sel<N_CH, io[force_sel]=1, force_sel!=active_sel. On accept: switch, reload holdoff.
    - If force_sel==active_sel: no action and no reject.
    - Otherwise: pulse force_rej.
  - force_swi in NONE is always rejected.
  - Holdoff counter: decrements to 0 and saturates there. It gates forced switches only; failover is never blocked.
- Simultaneous events:
  - Failure of the active channel and force_swi in the same cycle: failover wins and force is rejected.
  - Several channels dying at once: evaluate the round-robin search on the same-cycle io.
- switch, active_sel and force_rej update in the same cycle, 1 clk after the triggering io change or force_swi.

Decomposition:
- Package heartbeat_pkg holds:
  - channel state encodings DEAD/RECOVER/ALIVE
  - arbiter state encodings NONE/RUN
  - the round-robin next-alive function
- Sub-module heartbeat_chan (sync, edge detect, counter, channel FSM; parameters CNT_W, TIMEOUT, MIN_EDGES), instantiated N_CH times by generate.

Test Plan:
Test parameters: N_CH=4, TIMEOUT=100, MIN_EDGES=3, HOLDOFF=50 unless noted.
- Reset, then a 40-cycle-period square wave on pwm[2] only -> io=4'b0100 after the third rising edge (+3 clk), active_sel=2, switch pulses once, all_dead falls.
- Channels 0,1,3 alive with active_sel=1; hold pwm[1] low -> io[1] falls 100 clk after the last edge, active_sel=3 the next cycle, one switch pulse.
- Channels 0 and 2 alive with active_sel=0:
  - force_swi with force_sel=2 at holdoff=10 -> force_rej pulses and active_sel stays 0.
  - Retry after holdoff reaches 0 -> active_sel=2 and switch pulses.
- In one cycle, io[active_sel] falls and force_swi targets a different alive channel -> round-robin failover target is selected and force_rej pulses.
- All channels stop toggling -> all_dead=1 and active_sel holds.
  - Restart pwm[3] -> alive after 3 edges, active_sel=3.
- Assert rst_n low for 1 clk while RECOVER has ecnt=2 -> all outputs return to reset values, and 3 fresh edges are needed for io to rise.

Source files
------------

// File: rtl/heartbeat_pkg.sv
// Shared encodings and the round-robin channel search for the heartbeat failover block.
package heartbeat_pkg;

    localparam int MAX_CH = 8;
    localparam int IDX_W  = 3;

    typedef logic [MAX_CH-1:0] ch_mask_t;
    typedef logic [IDX_W-1:0]  ch_idx_t;

    typedef enum logic [1:0] {
        DEAD    = 2'd0,
        RECOVER = 2'd1,
        ALIVE   = 2'd2
    } chan_state_e;

    typedef enum logic {
        NONE = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    // First alive channel strictly after cur, wrapping at n_ch-1; cur itself is tried last.
    function automatic ch_idx_t next_alive(input ch_mask_t alive, input ch_idx_t cur,
                                           input int n_ch);
        ch_idx_t sel;
        logic    found;
        int      idx;
        sel   = cur;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = (int'(cur) + k) % n_ch;
            if (!found && (k <= n_ch) && alive[idx[IDX_W-1:0]]) begin
                sel   = ch_idx_t'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/heartbeat_failover_if.sv
// Command/status bus between the failover arbiter and the core switch command logic.
interface heartbeat_failover_if #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
);
    logic             force_swi;
    logic [SEL_W-1:0] force_sel;
    logic [N_CH-1:0]  io;
    logic [SEL_W-1:0] active_sel;
    logic             switch;
    logic             all_dead;
    logic             force_rej;

    modport master (
        output force_swi, force_sel,
        input  io, active_sel, switch, all_dead, force_rej
    );

    modport slave (
        input  force_swi, force_sel,
        output io, active_sel, switch, all_dead, force_rej
    );
endinterface

// File: rtl/heartbeat_chan.sv
// One heartbeat monitor: synchroniser, rising-edge detect, timeout counter and alive FSM.
module heartbeat_chan
    import heartbeat_pkg::*;
#(
    parameter int             CNT_W     = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = 24'd2_000_000,
    parameter int             MIN_EDGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm,
    output logic alive
);

    logic             sync_p0, sync_p1, sync_p2;
    logic             rise;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       ecnt, ecnt_next;
    logic             timeout;
    chan_state_e      state, state_next;

    // stage p0/p1: two-flop synchroniser, p2: delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= pwm;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~sync_p2;

    always_comb begin
        cnt_next = cnt;
        if (rise) begin
            cnt_next = '0;
        end else if (cnt != TIMEOUT) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Timeout fires on the cycle the counter lands on TIMEOUT, and keeps firing while saturated.
    assign timeout = (cnt_next == TIMEOUT);

    always_comb begin
        state_next = state;
        ecnt_next  = ecnt;
        case (state)
            DEAD: begin
                if (rise) begin
                    if (MIN_EDGES <= 1) begin
                        state_next = ALIVE;
                    end else begin
                        state_next = RECOVER;
                        ecnt_next  = 4'd1;
                    end
                end
            end
            RECOVER: begin
                if (rise) begin
                    ecnt_next = ecnt + 4'd1;
                    if ((ecnt + 4'd1) == 4'(MIN_EDGES)) begin
                        state_next = ALIVE;
                        ecnt_next  = 4'd0;
                    end
                end else if (timeout) begin
                    state_next = DEAD;
                    ecnt_next  = 4'd0;
                end
            end
            ALIVE: begin
                if (timeout) begin
                    state_next = DEAD;
                end
            end
            default: begin
                state_next = DEAD;
                ecnt_next  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            ecnt  <= 4'd0;
            state <= DEAD;
            alive <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            ecnt  <= ecnt_next;
            state <= state_next;
            alive <= (state_next == ALIVE);
        end
    end

endmodule

// File: rtl/heartbeat_failover.sv
// N-channel heartbeat monitor with round-robin failover and hold-off gated forced switching.
module heartbeat_failover
    import heartbeat_pkg::*;
#(
    parameter int               N_CH      = 4,
    parameter int               SEL_W     = 2,
    parameter int               CNT_W     = 24,
    parameter logic [CNT_W-1:0] TIMEOUT   = 24'd2_000_000,
    parameter int               MIN_EDGES = 3,
    parameter logic [CNT_W-1:0] HOLDOFF   = 24'd500_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pwm,
    heartbeat_failover_if.slave bus
);

    logic [N_CH-1:0]  io;
    ch_mask_t         mask;
    arb_state_e       state, state_next;
    logic [SEL_W-1:0] active_sel, sel_next;
    logic             switch_pulse, switch_next;
    logic             reject_pulse, reject_next;
    logic             none_flag;
    logic [CNT_W-1:0] holdoff, holdoff_next;
    logic             active_alive;
    logic             force_ok;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        heartbeat_chan #(
            .CNT_W    (CNT_W),
            .TIMEOUT  (TIMEOUT),
            .MIN_EDGES(MIN_EDGES)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .pwm  (pwm[i]),
            .alive(io[i])
        );
    end

    assign mask         = ch_mask_t'(io);
    assign active_alive = mask[ch_idx_t'(active_sel)];
    assign force_ok     = (int'(bus.force_sel) < N_CH) && mask[ch_idx_t'(bus.force_sel)];

    always_comb begin
        state_next   = state;
        sel_next     = active_sel;
        switch_next  = 1'b0;
        reject_next  = 1'b0;
        holdoff_next = (holdoff != '0) ? holdoff - 1'b1 : '0;
        case (state)
            NONE: begin
                if (bus.force_swi) begin
                    reject_next = 1'b1;
                end
                if (|io) begin
                    sel_next     = SEL_W'(next_alive(mask, ch_idx_t'(N_CH - 1), N_CH));
                    switch_next  = (sel_next != active_sel);
                    holdoff_next = HOLDOFF;
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (!active_alive) begin
                    // Failover takes priority over any force request arriving in the same cycle.
                    if (bus.force_swi && (bus.force_sel != active_sel)) begin
                        reject_next = 1'b1;
                    end
                    if (|io) begin
                        sel_next     = SEL_W'(next_alive(mask, ch_idx_t'(active_sel), N_CH));
                        switch_next  = 1'b1;
                        holdoff_next = HOLDOFF;
                    end else begin
                        state_next = NONE;
                    end
                end else if (bus.force_swi && (bus.force_sel != active_sel)) begin
                    if ((holdoff == '0) && force_ok) begin
                        sel_next     = bus.force_sel;
                        switch_next  = 1'b1;
                        holdoff_next = HOLDOFF;
                    end else begin
                        reject_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NONE;
            active_sel   <= '0;
            switch_pulse <= 1'b0;
            reject_pulse <= 1'b0;
            none_flag    <= 1'b1;
            holdoff      <= '0;
        end else begin
            state        <= state_next;
            active_sel   <= sel_next;
            switch_pulse <= switch_next;
            reject_pulse <= reject_next;
            none_flag    <= (state_next == NONE);
            holdoff      <= holdoff_next;
        end
    end

    assign bus.io         = io;
    assign bus.active_sel = active_sel;
    assign bus.switch     = switch_pulse;
    assign bus.all_dead   = none_flag;
    assign bus.force_rej  = reject_pulse;

endmodule
